lcd_write_arbiter: RTL and testbench



---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_write_arbiter_if.sv | 26 ++
 rtl/lcd_rr_arbiter.sv | 30 +++
 rtl/lcd_write_arbiter.sv | 133 +++++++++++++
 tb/tb_lcd_write_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD write-path constants, FSM state encoding and request record.
// Imported by the write arbiter and its sub-modules.
package lcd_pkg;

   localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
   localparam logic [7:0] LCD_LINE2_OFFSET  = 8'h40;
   localparam int         LCD_COLS          = 16;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_WAIT,
      ADDR_DLY,
      CHAR,
      CHAR_WAIT,
      CHAR_DLY
   } lcd_state_e;

   typedef struct packed {
      logic       line;
      logic [3:0] col;
      logic [7:0] chr;
   } lcd_req_t;

   // DDRAM set-address command for a (line, column) position
   function automatic logic [7:0] lcdAddrCmd(input logic line, input logic [3:0] col);
      return LCD_CMD_SET_DDRAM | (line ? LCD_LINE2_OFFSET : 8'h00) | {4'h0, col};
   endfunction

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Requester-side and LCD_Controller-side signals of the LCD write arbiter.
// slave = arbiter view, master = requesters/controller (or testbench) view.
interface lcd_write_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]   iREQ;
   logic [NREQ-1:0]   iREQ_LINE;
   logic [4*NREQ-1:0] iREQ_COL;
   logic [8*NREQ-1:0] iREQ_CHAR;
   logic [NREQ-1:0]   oGNT;
   logic              oBUSY;
   logic [7:0]        oLCD_DATA;
   logic              oLCD_RS;
   logic              oLCD_START;
   logic              iLCD_DONE;

   modport slave (
      input  iREQ, iREQ_LINE, iREQ_COL, iREQ_CHAR, iLCD_DONE,
      output oGNT, oBUSY, oLCD_DATA, oLCD_RS, oLCD_START
   );

   modport master (
      output iREQ, iREQ_LINE, iREQ_COL, iREQ_CHAR, iLCD_DONE,
      input  oGNT, oBUSY, oLCD_DATA, oLCD_RS, oLCD_START
   );
endinterface

// File: rtl/lcd_rr_arbiter.sv
// Round-robin priority select: first set request at or above iPTR, with wrap.
// Purely combinational; the owner keeps and advances the pointer.
module lcd_rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  iREQ,
   input  logic [PW-1:0] iPTR,
   output logic [N-1:0]  oGNT,
   output logic [PW-1:0] oIDX,
   output logic          oVALID
);

   always_comb begin
      int k;
      k      = 0;
      oGNT   = '0;
      oIDX   = '0;
      oVALID = 1'b0;
      for (int i = 0; i < N; i++) begin
         k = (int'(iPTR) + i) % N;
         if (!oVALID && iREQ[k]) begin
            oVALID  = 1'b1;
            oGNT[k] = 1'b1;
            oIDX    = PW'(k);
         end
      end
   end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares the LCD_Controller write port among NREQ character requesters:
// set-address command, then data byte, each with start/done handshake and settle delay.
// Optional cursor tracking (skips redundant address commands): define LCD_ADDR_CACHE_EN.
module lcd_write_arbiter
   import lcd_pkg::*;
#(
   parameter int NREQ       = 2,
   parameter int DLY_CYCLES = 262143,
   parameter int DLY_W      = 18
) (
   input  logic                iCLK,
   input  logic                iRST,
   lcd_write_arbiter_if.slave  bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   lcd_state_e       state, stateNxt;
   logic [PW-1:0]    rrPtr;
   logic [PW-1:0]    selIdx;
   logic [NREQ-1:0]  selGnt;
   logic             anyReq;
   logic [NREQ-1:0]  gntQ;
   lcd_req_t         sel, cur;
   logic [DLY_W-1:0] dlyCnt;
   logic             dlyDone;
   logic             cacheHit;

   lcd_rr_arbiter #(.N(NREQ), .PW(PW)) uRrArb (
      .iREQ   (bus.iREQ),
      .iPTR   (rrPtr),
      .oGNT   (selGnt),
      .oIDX   (selIdx),
      .oVALID (anyReq)
   );

   always_comb begin
      sel.line = bus.iREQ_LINE[selIdx];
      sel.col  = bus.iREQ_COL[int'(selIdx)*4 +: 4];
      sel.chr  = bus.iREQ_CHAR[int'(selIdx)*8 +: 8];
   end

   assign dlyDone = (dlyCnt == DLY_W'(DLY_CYCLES - 1));

`ifdef LCD_ADDR_CACHE_EN
   logic       curValid;
   logic [4:0] curPos;

   assign cacheHit = curValid && (curPos == {sel.line, sel.col});

   // The LCD auto-increments after each data write; past column 15 it lands
   // outside the visible DDRAM window, so the cursor is no longer trusted.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         curValid <= 1'b0;
         curPos   <= '0;
      end else if (state == CHAR_WAIT && bus.iLCD_DONE) begin
         if (cur.col == 4'(LCD_COLS - 1)) begin
            curValid <= 1'b0;
            curPos   <= {cur.line, 4'h0};
         end else begin
            curValid <= 1'b1;
            curPos   <= {cur.line, cur.col + 4'd1};
         end
      end
   end
`else
   assign cacheHit = 1'b0;
`endif

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE:      if (anyReq) stateNxt = cacheHit ? CHAR : ADDR;
         ADDR:      stateNxt = ADDR_WAIT;
         ADDR_WAIT: if (bus.iLCD_DONE) stateNxt = ADDR_DLY;
         ADDR_DLY:  if (dlyDone) stateNxt = CHAR;
         CHAR:      stateNxt = CHAR_WAIT;
         CHAR_WAIT: if (bus.iLCD_DONE) stateNxt = CHAR_DLY;
         CHAR_DLY:  if (dlyDone) stateNxt = IDLE;
         default:   stateNxt = IDLE;
      endcase
   end

   // Data and RS depend only on state and the latched request, so they are
   // stable for the whole time START is high.
   always_comb begin
      bus.oLCD_DATA  = 8'h00;
      bus.oLCD_RS    = 1'b0;
      bus.oLCD_START = 1'b0;
      case (state)
         ADDR, ADDR_WAIT: begin
            bus.oLCD_DATA  = lcdAddrCmd(cur.line, cur.col);
            bus.oLCD_START = 1'b1;
         end
         ADDR_DLY: bus.oLCD_DATA = lcdAddrCmd(cur.line, cur.col);
         CHAR, CHAR_WAIT: begin
            bus.oLCD_DATA  = cur.chr;
            bus.oLCD_RS    = 1'b1;
            bus.oLCD_START = 1'b1;
         end
         CHAR_DLY: begin
            bus.oLCD_DATA = cur.chr;
            bus.oLCD_RS   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state  <= IDLE;
         rrPtr  <= '0;
         gntQ   <= '0;
         cur    <= '0;
         dlyCnt <= '0;
      end else begin
         state <= stateNxt;
         gntQ  <= '0;
         if (state == IDLE && anyReq) begin
            gntQ  <= selGnt;
            cur   <= sel;
            rrPtr <= (selIdx == PW'(NREQ - 1)) ? '0 : selIdx + 1'b1;
         end
         if (state == ADDR_DLY || state == CHAR_DLY)
            dlyCnt <= dlyDone ? '0 : dlyCnt + 1'b1;
      end
   end

   assign bus.oGNT  = gntQ;
   assign bus.oBUSY = (state != IDLE);

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Self-checking bench for lcd_write_arbiter: vector table, hand-written corner
// sequences and randomized rounds against a transaction-level reference model.
module tb_lcd_write_arbiter;
   localparam int NREQ = 2;
   localparam int DLY  = 4;
   localparam int DW   = 3;

   typedef struct packed {
      logic       rs;
      logic [7:0] d;
   } wr_t;

   typedef struct {
      int              k;
      logic            line;
      logic [3:0]      col;
      logic [7:0]      ch;
      logic [NREQ-1:0] expGnt;
      logic [7:0]      expAddr;
      int              expBusy;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lcd_write_arbiter_if #(.NREQ(NREQ)) bus ();

   lcd_write_arbiter #(.NREQ(NREQ), .DLY_CYCLES(DLY), .DLY_W(DW)) dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   int nErr = 0;
   int nChk = 0;

   // LCD_Controller model: one-cycle oDone doneDly cycles after iStart rises
   int   doneDly = 3;
   int   tmr = 0;
   logic startD = 1'b0;
   logic spur = 1'b0;
   always @(posedge clk) begin
      startD <= bus.oLCD_START;
      if (rst) tmr <= 0;
      else if (bus.oLCD_START && !startD) tmr <= doneDly;
      else if (tmr > 0) tmr <= tmr - 1;
   end
   assign bus.iLCD_DONE = (tmr == 1) || spur;

   wr_t actQ[$];
   always @(posedge clk)
      if (bus.oLCD_START && !startD) actQ.push_back({bus.oLCD_RS, bus.oLCD_DATA});

   // Reference model state
   logic       reqLine[NREQ];
   int         reqCol[NREQ];
   logic [7:0] reqChar[NREQ];
   int         refPtr = 0;
   wr_t        expQ[$];
   bit         cv = 0;
   int         cl = 0, cc = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChk++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int refPick(input logic [NREQ-1:0] m);
      for (int i = 0; i < NREQ; i++)
         if (m[(refPtr + i) % NREQ]) return (refPtr + i) % NREQ;
      return -1;
   endfunction

   task automatic refServe(input int k);
      int         ln, c;
      logic [7:0] a;
      ln = int'(reqLine[k]);
      c  = reqCol[k];
      a  = 8'(8'h80 + (ln != 0 ? 8'h40 : 8'h00) + c);
      refPtr = (k + 1) % NREQ;
`ifdef LCD_ADDR_CACHE_EN
      if (!(cv && cl == ln && cc == c)) expQ.push_back({1'b0, a});
      cl = ln;
      if (c == 15) begin cv = 0; cc = 0; end
      else begin cv = 1; cc = c + 1; end
`else
      expQ.push_back({1'b0, a});
`endif
      expQ.push_back({1'b1, reqChar[k]});
   endtask

   task automatic refReset();
      refPtr = 0; cv = 0; cl = 0; cc = 0;
      actQ.delete(); expQ.delete();
   endtask

   task automatic driveReq(input logic [NREQ-1:0] p);
      logic [NREQ-1:0]   l;
      logic [4*NREQ-1:0] c;
      logic [8*NREQ-1:0] ch;
      for (int k = 0; k < NREQ; k++) begin
         l[k]         = reqLine[k];
         c[4*k +: 4]  = 4'(reqCol[k]);
         ch[8*k +: 8] = reqChar[k];
      end
      bus.iREQ      = p;
      bus.iREQ_LINE = l;
      bus.iREQ_COL  = c;
      bus.iREQ_CHAR = ch;
   endtask

   task automatic randContent(input int k);
      reqLine[k] = 1'($urandom_range(0, 1));
      reqCol[k]  = int'($urandom_range(0, 15));
      reqChar[k] = 8'($urandom_range(32, 126));
   endtask

   task automatic compareLogs();
      check("log_len", actQ.size(), expQ.size());
      for (int i = 0; i < actQ.size() && i < expQ.size(); i++)
         check("log_entry", actQ[i], expQ[i]);
      actQ.delete(); expQ.delete();
   endtask

   task automatic waitIdle();
      bit ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (!bus.oBUSY) begin ok = 1; break; end
      end
      check("idle_reached", ok, 1);
   endtask

   // Serve a set of held requests; granted requesters drop (or re-request)
   task automatic serveAll(input logic [NREQ-1:0] mask, input bit reReq,
                           output logic [NREQ-1:0] firstGnt, output int busyCnt, output int gntLat);
      logic [NREQ-1:0] pending, oh;
      int  k, ng;
      bit  fin;
      pending = mask; ng = 0; fin = 0;
      busyCnt = 0; gntLat = -1; firstGnt = '0;
      driveReq(pending);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         if (bus.oBUSY) busyCnt++;
         if (bus.oGNT != '0) begin
            k  = refPick(pending);
            oh = (k >= 0) ? NREQ'(1 << k) : '0;
            check("grant_sel", bus.oGNT, oh);
            if (gntLat < 0) begin gntLat = cyc; firstGnt = bus.oGNT; end
            if (k >= 0) refServe(k);
            pending &= ~bus.oGNT;
            ng++;
            if (reReq && k >= 0 && ng < 6 && $urandom_range(0, 2) == 0) begin
               randContent(k);
               pending[k] = 1'b1;
            end
            driveReq(pending);
         end
         if (pending == '0 && !bus.oBUSY) begin fin = 1; break; end
      end
      check("serve_done", fin, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   vec_t            vt[4];
   logic [NREQ-1:0] g;
   int              bc, lat, n;
   logic [7:0]      d0;
   logic            rs0;
   bit              ok;

   initial begin
      vt[0] = '{0, 1'b1, 4'd5,  8'h41, 2'b01, 8'hC5, 16};
      vt[1] = '{1, 1'b0, 4'd0,  8'h5A, 2'b10, 8'h80, 16};
      vt[2] = '{0, 1'b0, 4'd15, 8'h7E, 2'b01, 8'h8F, 16};
      vt[3] = '{1, 1'b1, 4'd15, 8'h20, 2'b10, 8'hCF, 16};

      for (int k = 0; k < NREQ; k++) begin reqLine[k] = 0; reqCol[k] = 0; reqChar[k] = 0; end
      rst = 1'b1;
      driveReq('0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt",   bus.oGNT, 0);
      check("rst_busy",  bus.oBUSY, 0);
      check("rst_data",  bus.oLCD_DATA, 0);
      check("rst_rs",    bus.oLCD_RS, 0);
      check("rst_start", bus.oLCD_START, 0);
      rst = 1'b0;
      refReset();

      // Single-request vectors
      for (int i = 0; i < 4; i++) begin
         reqLine[vt[i].k] = vt[i].line;
         reqCol[vt[i].k]  = int'(vt[i].col);
         reqChar[vt[i].k] = vt[i].ch;
         serveAll(NREQ'(1 << vt[i].k), 0, g, bc, lat);
         check("tv_gnt",  g, vt[i].expGnt);
         check("tv_lat",  lat, 0);
         check("tv_busy", bc, vt[i].expBusy);
         check("tv_nwr",  actQ.size(), 2);
         if (actQ.size() >= 2) begin
            check("tv_addr", actQ[0], {1'b0, vt[i].expAddr});
            check("tv_char", actQ[1], {1'b1, vt[i].ch});
         end
         actQ.delete(); expQ.delete();
      end

      // Contention: both held, grants must alternate starting at requester 0
      reqLine[0] = 0; reqCol[0] = 2; reqChar[0] = 8'h61;
      reqLine[1] = 1; reqCol[1] = 7; reqChar[1] = 8'h62;
      driveReq(2'b11);
      n = 0; ok = 0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         @(posedge clk); #1;
         if (bus.oGNT != '0) begin
            check("cont_gnt", bus.oGNT, (n % 2 == 0) ? 2'b01 : 2'b10);
            refServe(refPick(2'b11));
            n++;
            if (n == 4) driveReq('0);
         end
         if (n == 4 && !bus.oBUSY) begin ok = 1; break; end
      end
      check("cont_done", ok, 1);
      check("cont_cnt", n, 4);
      compareLogs();

      // Handshake hold: slow oDone, outputs must not move while START is high
      doneDly = 20;
      reqLine[0] = 1; reqCol[0] = 9; reqChar[0] = 8'h48;
      driveReq(2'b01);
      ok = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(posedge clk); #1;
         if (bus.oLCD_START) begin ok = 1; break; end
      end
      check("hold_rise", ok, 1);
      driveReq('0);
      refServe(0);
      d0 = bus.oLCD_DATA; rs0 = bus.oLCD_RS;
      check("hold_first", d0, 8'hC9);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("hold_start", bus.oLCD_START, 1);
         check("hold_data",  bus.oLCD_DATA, d0);
         check("hold_rs",    bus.oLCD_RS, rs0);
      end
      doneDly = 3;
      waitIdle();
      compareLogs();

      // Spurious oDone while idle
      spur = 1'b1;
      @(posedge clk); #1;
      spur = 1'b0;
      check("spur_busy",  bus.oBUSY, 0);
      check("spur_start", bus.oLCD_START, 0);
      @(posedge clk); #1;
      check("spur_busy2", bus.oBUSY, 0);

      // Reset during the data handshake; pointer must return to 0
      doneDly = 10;
      reqLine[0] = 0; reqCol[0] = 4; reqChar[0] = 8'h52;
      driveReq(2'b01);
      @(posedge clk); #1;
      check("mid_gnt", bus.oGNT, 2'b01);
      driveReq('0);
      ok = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(posedge clk); #1;
         if (bus.oLCD_START && bus.oLCD_RS) begin ok = 1; break; end
      end
      check("mid_char", ok, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_start", bus.oLCD_START, 0);
      check("mid_busy",  bus.oBUSY, 0);
      check("mid_gnt0",  bus.oGNT, 0);
      rst = 1'b0;
      refReset();
      doneDly = 3;
      reqLine[0] = 1; reqCol[0] = 1; reqChar[0] = 8'h31;
      reqLine[1] = 0; reqCol[1] = 8; reqChar[1] = 8'h32;
      serveAll(2'b11, 0, g, bc, lat);
      check("rst_ptr", g, 2'b01);
      compareLogs();

      // Randomized rounds against the reference model
      for (int r = 0; r < 25; r++) begin
         for (int k = 0; k < NREQ; k++) randContent(k);
         serveAll(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1, g, bc, lat);
         compareLogs();
      end

`ifdef LCD_ADDR_CACHE_EN
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      refReset();
      reqLine[0] = 0; reqCol[0] = 3; reqChar[0] = 8'h33;
      serveAll(2'b01, 0, g, bc, lat);
      reqCol[0] = 4; reqChar[0] = 8'h34;
      serveAll(2'b01, 0, g, bc, lat);
      check("cache_nwr", actQ.size(), 3);
      if (actQ.size() == 3) begin
         check("cache_a", actQ[0], {1'b0, 8'h83});
         check("cache_c4", actQ[2], {1'b1, 8'h34});
      end
      actQ.delete(); expQ.delete();
      reqCol[0] = 15; reqChar[0] = 8'h46;
      serveAll(2'b01, 0, g, bc, lat);
      reqCol[0] = 0; reqChar[0] = 8'h30;
      serveAll(2'b01, 0, g, bc, lat);
      check("wrap_nwr", actQ.size(), 4);
      if (actQ.size() == 4) check("wrap_addr", actQ[2], {1'b0, 8'h80});
      actQ.delete(); expQ.delete();
`endif

      $display("Result: errors=%0d of %0d checks", nErr, nChk);
      $finish;
   end

endmodule
